pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Generates per-register enable and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable and redirect.
- Resolves load-use hazards, branch/jump redirects, data-memory wait, instruction-fetch wait and multi-cycle EX operations (MDU), with a small FSM for the multi-cycle cases.
- Keeps a saturating front-end stall-cycle counter for performance debug.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        KILL    = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_GO     = '{en: 1'b1, flush: 1'b0};
    localparam stage_ctrl_t STAGE_HOLD   = '{en: 1'b0, flush: 1'b0};
    // A bubble always carries en=1 so the consuming register actually loads it.
    localparam stage_ctrl_t STAGE_BUBBLE = '{en: 1'b1, flush: 1'b1};
    localparam stage_ctrl_t STAGE_OFF    = '{en: 1'b0, flush: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use and data-memory-wait hazard terms.
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  mem_req,
    input  logic                  dmem_ready,
    output logic                  load_use,
    output logic                  mem_stall
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

    // x0 never carries a dependency
    assign load_use  = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);
    assign mem_stall = mem_req && !dmem_ready;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with a saturating
// front-end stall counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic [XLEN-1:0]       ex_redirect_target,
    input  logic                  ex_mc_start,
    input  logic                  mc_done,
    input  logic                  imem_ready,
    input  logic                  mem_req,
    input  logic                  dmem_ready,
    output logic                  pc_en,
    output logic                  pc_redirect,
    output logic [XLEN-1:0]       pc_redirect_target,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_en,
    output logic                  id_ex_flush,
    output logic                  ex_mem_en,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_en,
    output logic                  mem_wb_flush,
    output logic [CNT_W-1:0]      stall_count
);

    ctrl_state_e     state_q;
    ctrl_state_e     state_d;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] target_d;
    logic [CNT_W-1:0] count_q;

    logic            load_use;
    logic            mem_stall;

    logic            pc_en_c;
    logic            pc_redirect_c;
    logic [XLEN-1:0] target_c;
    stage_ctrl_t     if_id_c;
    stage_ctrl_t     id_ex_c;
    stage_ctrl_t     ex_mem_c;
    stage_ctrl_t     mem_wb_c;

    pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .mem_req     (mem_req),
        .dmem_ready  (dmem_ready),
        .load_use    (load_use),
        .mem_stall   (mem_stall)
    );

    // State and latched redirect target
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        pc_en_c       = 1'b1;
        pc_redirect_c = 1'b0;
        target_c      = '0;
        if_id_c       = STAGE_GO;
        id_ex_c       = STAGE_GO;
        ex_mem_c      = STAGE_GO;
        mem_wb_c      = STAGE_GO;

        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    pc_en_c  = 1'b0;
                    if_id_c  = STAGE_HOLD;
                    id_ex_c  = STAGE_HOLD;
                    ex_mem_c = STAGE_HOLD;
                    mem_wb_c = STAGE_BUBBLE;
                end else if (ex_mc_start) begin
                    pc_en_c  = 1'b0;
                    if_id_c  = STAGE_HOLD;
                    id_ex_c  = STAGE_HOLD;
                    ex_mem_c = STAGE_BUBBLE;
                    state_d  = MC_WAIT;
                end else if (ex_redirect) begin
                    // Redirect wins over load-use: the ID instruction dies here
                    target_c = ex_redirect_target;
                    if_id_c  = STAGE_BUBBLE;
                    id_ex_c  = STAGE_BUBBLE;
                    if (imem_ready) begin
                        pc_redirect_c = 1'b1;
                    end else begin
                        pc_en_c  = 1'b0;
                        target_d = ex_redirect_target;
                        state_d  = KILL;
                    end
                end else if (load_use) begin
                    pc_en_c = 1'b0;
                    if_id_c = STAGE_HOLD;
                    id_ex_c = STAGE_BUBBLE;
                end else if (!imem_ready) begin
                    pc_en_c = 1'b0;
                    if_id_c = STAGE_BUBBLE;
                end
            end

            MC_WAIT: begin
                pc_en_c = 1'b0;
                if_id_c = STAGE_HOLD;
                id_ex_c = STAGE_HOLD;
                if (mem_stall) begin
                    ex_mem_c = STAGE_HOLD;
                    mem_wb_c = STAGE_BUBBLE;
                end else if (mc_done) begin
                    ex_mem_c = STAGE_GO;
                    state_d  = RUN;
                end else begin
                    ex_mem_c = STAGE_BUBBLE;
                end
            end

            KILL: begin
                // The fetch in flight belongs to the wrong path; drop it until imem answers
                pc_en_c  = 1'b0;
                if_id_c  = STAGE_BUBBLE;
                target_c = target_q;
                if (mem_stall) begin
                    id_ex_c  = STAGE_HOLD;
                    ex_mem_c = STAGE_HOLD;
                    mem_wb_c = STAGE_BUBBLE;
                end else begin
                    if (ex_redirect) begin
                        target_d = ex_redirect_target;
                        target_c = ex_redirect_target;
                        id_ex_c  = STAGE_BUBBLE;
                    end
                    if (imem_ready) begin
                        pc_en_c       = 1'b1;
                        pc_redirect_c = 1'b1;
                        state_d       = RUN;
                    end
                end
            end

            default: begin
                state_d  = RUN;
                target_d = '0;
            end
        endcase
    end

    assign pc_en              = !reset && pc_en_c;
    assign pc_redirect        = !reset && pc_redirect_c;
    assign pc_redirect_target = reset ? '0 : target_c;
    assign if_id_en           = !reset && if_id_c.en;
    assign if_id_flush        = !reset && if_id_c.flush;
    assign id_ex_en           = !reset && id_ex_c.en;
    assign id_ex_flush        = !reset && id_ex_c.flush;
    assign ex_mem_en          = !reset && ex_mem_c.en;
    assign ex_mem_flush       = !reset && ex_mem_c.flush;
    assign mem_wb_en          = !reset && mem_wb_c.en;
    assign mem_wb_flush       = !reset && mem_wb_c.flush;

    // Saturating count of cycles where the PC did not advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (!pc_en_c && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign stall_count = count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with hand-computed control patterns.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    // {pc_en, pc_redirect, if_id en/flush, id_ex en/flush, ex_mem en/flush, mem_wb en/flush}
    localparam logic [9:0] C_NORMAL    = 10'b1010101010;
    localparam logic [9:0] C_LOAD_USE  = 10'b0000111010;
    localparam logic [9:0] C_REDIR_RDY = 10'b1111111010;
    localparam logic [9:0] C_REDIR_WT  = 10'b0011111010;
    localparam logic [9:0] C_KILL_WT   = 10'b0011101010;
    localparam logic [9:0] C_KILL_GO   = 10'b1111101010;
    localparam logic [9:0] C_IMEM_WT   = 10'b0011101010;
    localparam logic [9:0] C_MC_WAIT   = 10'b0000001110;
    localparam logic [9:0] C_MC_DONE   = 10'b0000001010;
    localparam logic [9:0] C_MEM_STALL = 10'b0000000011;
    localparam logic [9:0] C_RESET     = 10'b0000000000;

    logic            clk;
    logic            reset;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic [4:0]      ex_rd;
    logic            ex_mem_read;
    logic            ex_redirect;
    logic [XLEN-1:0] ex_redirect_target;
    logic            ex_mc_start;
    logic            mc_done;
    logic            imem_ready;
    logic            mem_req;
    logic            dmem_ready;
    logic            pc_en;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_redirect_target;
    logic            if_id_en;
    logic            if_id_flush;
    logic            id_ex_en;
    logic            id_ex_flush;
    logic            ex_mem_en;
    logic            ex_mem_flush;
    logic            mem_wb_en;
    logic            mem_wb_flush;
    logic [CNT_W-1:0] stall_count;

    logic [9:0]      ctl;
    logic [CNT_W-1:0] exp_cnt;
    int              checks;
    int              errors;

    pipeline_hazard_ctrl #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .id_rs1             (id_rs1),
        .id_rs2             (id_rs2),
        .id_uses_rs1        (id_uses_rs1),
        .id_uses_rs2        (id_uses_rs2),
        .ex_rd              (ex_rd),
        .ex_mem_read        (ex_mem_read),
        .ex_redirect        (ex_redirect),
        .ex_redirect_target (ex_redirect_target),
        .ex_mc_start        (ex_mc_start),
        .mc_done            (mc_done),
        .imem_ready         (imem_ready),
        .mem_req            (mem_req),
        .dmem_ready         (dmem_ready),
        .pc_en              (pc_en),
        .pc_redirect        (pc_redirect),
        .pc_redirect_target (pc_redirect_target),
        .if_id_en           (if_id_en),
        .if_id_flush        (if_id_flush),
        .id_ex_en           (id_ex_en),
        .id_ex_flush        (id_ex_flush),
        .ex_mem_en          (ex_mem_en),
        .ex_mem_flush       (ex_mem_flush),
        .mem_wb_en          (mem_wb_en),
        .mem_wb_flush       (mem_wb_flush),
        .stall_count        (stall_count)
    );

    assign ctl = {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                  ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs1             = 5'd0;
        id_rs2             = 5'd0;
        id_uses_rs1        = 1'b0;
        id_uses_rs2        = 1'b0;
        ex_rd              = 5'd0;
        ex_mem_read        = 1'b0;
        ex_redirect        = 1'b0;
        ex_redirect_target = 32'h0;
        ex_mc_start        = 1'b0;
        mc_done            = 1'b0;
        imem_ready         = 1'b1;
        mem_req            = 1'b0;
        dmem_ready         = 1'b1;
    endtask

    // Inputs are already applied; check this cycle's controls, then advance one clock.
    task automatic step(input string tag, input logic [9:0] exp_ctl, input logic [31:0] exp_tgt);
        #2;
        check(tag, 32'(ctl), 32'(exp_ctl));
        check({tag, ".tgt"}, pc_redirect_target, exp_tgt);
        check({tag, ".cnt"}, 32'(stall_count), 32'(exp_cnt));
        @(posedge clk);
        if (!exp_ctl[9] && (exp_cnt != {CNT_W{1'b1}})) exp_cnt = exp_cnt + CNT_W'(1);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = '0;
        reset   = 1'b1;
        idle();
        ex_redirect        = 1'b1;
        ex_redirect_target = 32'h55;
        @(posedge clk);
        #3;
        check("reset.ctl", 32'(ctl), 32'(C_RESET));
        check("reset.tgt", pc_redirect_target, 32'h0);
        check("reset.cnt", 32'(stall_count), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();

        step("idle", C_NORMAL, 32'h0);

        // Load-use on rs1, then the load has moved on
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        step("lu_rs1", C_LOAD_USE, 32'h0);
        ex_mem_read = 1'b0;
        step("lu_after", C_NORMAL, 32'h0);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        step("lu_x0", C_NORMAL, 32'h0);
        ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; id_uses_rs1 = 1'b0;
        step("lu_rs2", C_LOAD_USE, 32'h0);
        id_uses_rs2 = 1'b0;
        step("lu_nouse", C_NORMAL, 32'h0);

        // Redirect with fetch ready, overriding a concurrent load-use
        id_uses_rs2 = 1'b1;
        ex_redirect = 1'b1; ex_redirect_target = 32'h0000_0100;
        step("redir_rdy", C_REDIR_RDY, 32'h100);
        idle();
        step("post_redir", C_NORMAL, 32'h0);

        // Redirect while fetch waits: KILL for 3 stalled cycles
        ex_redirect = 1'b1; ex_redirect_target = 32'h200; imem_ready = 1'b0;
        step("redir_wt", C_REDIR_WT, 32'h200);
        ex_redirect = 1'b0; ex_redirect_target = 32'hDEAD;
        step("kill_wt1", C_KILL_WT, 32'h200);
        step("kill_wt2", C_KILL_WT, 32'h200);
        imem_ready = 1'b1;
        step("kill_go", C_KILL_GO, 32'h200);
        idle();
        step("post_kill", C_NORMAL, 32'h0);

        // New redirect in KILL replaces the latched target
        ex_redirect = 1'b1; ex_redirect_target = 32'h300; imem_ready = 1'b0;
        step("redir2_wt", C_REDIR_WT, 32'h300);
        ex_redirect_target = 32'h340;
        step("kill_new", C_REDIR_WT, 32'h340);
        ex_redirect = 1'b0; ex_redirect_target = 32'h0; imem_ready = 1'b1;
        step("kill2_go", C_KILL_GO, 32'h340);

        // Plain fetch wait
        imem_ready = 1'b0;
        step("imem_wt", C_IMEM_WT, 32'h0);
        imem_ready = 1'b1;
        step("imem_rdy", C_NORMAL, 32'h0);

        // Multi-cycle op, done after 4 cycles
        ex_mc_start = 1'b1;
        step("mc_start", C_MC_WAIT, 32'h0);
        step("mc_w1", C_MC_WAIT, 32'h0);
        step("mc_w2", C_MC_WAIT, 32'h0);
        step("mc_w3", C_MC_WAIT, 32'h0);
        mc_done = 1'b1;
        step("mc_done", C_MC_DONE, 32'h0);
        idle();
        step("post_mc", C_NORMAL, 32'h0);

        // mem_stall defers mc_done acceptance
        ex_mc_start = 1'b1;
        step("mc2_start", C_MC_WAIT, 32'h0);
        mc_done = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0;
        step("mc2_mstall", C_MEM_STALL, 32'h0);
        dmem_ready = 1'b1;
        step("mc2_done", C_MC_DONE, 32'h0);
        idle();
        step("post_mc2", C_NORMAL, 32'h0);

        // mem_stall outranks redirect and load-use
        mem_req = 1'b1; dmem_ready = 1'b0;
        ex_redirect = 1'b1; ex_redirect_target = 32'h400;
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
        step("sim_ms1", C_MEM_STALL, 32'h0);
        step("sim_ms2", C_MEM_STALL, 32'h0);
        dmem_ready = 1'b1;
        step("sim_redir", C_REDIR_RDY, 32'h400);
        idle();
        step("post_sim", C_NORMAL, 32'h0);

        // Asynchronous reset in MC_WAIT
        ex_mc_start = 1'b1;
        step("mc3_start", C_MC_WAIT, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("arst.ctl", 32'(ctl), 32'(C_RESET));
        check("arst.cnt", 32'(stall_count), 32'h0);
        exp_cnt = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        step("arst_run", C_NORMAL, 32'h0);

        // Reset in KILL discards the latched target
        ex_redirect = 1'b1; ex_redirect_target = 32'h500; imem_ready = 1'b0;
        step("redir3_wt", C_REDIR_WT, 32'h500);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_cnt = '0;
        idle();
        step("krst_run", C_NORMAL, 32'h0);

        // Saturation of the stall counter
        imem_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step($sformatf("sat%0d", i), C_IMEM_WT, 32'h0);
        end
        check("sat_hold", 32'(stall_count), 32'hF);
        imem_ready = 1'b1;
        step("post_sat", C_NORMAL, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
